// File: rtl/bitblaster_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : bitblaster_pkg
// Purpose  : Shared opcode fields, sequencer state encoding and ld decode.
// Revision : 1.0
// ---------------------------------------------------------------------------
package bitblaster_pkg;

  localparam logic [3:0] OPC_LD_NIB  = 4'b0000;
  localparam logic [1:0] OPC_FMT_REG = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_HI       = 3'd2,
    ST_LO       = 3'd3,
    ST_FINISHED = 3'd4,
    ST_ERROR    = 3'd5
  } seq_state_t;

  // An ld carries its operand in the following program word.
  function automatic logic is_ld_word(input logic [9:0] word);
    return (word[9:8] == OPC_FMT_REG) && (word[3:0] == OPC_LD_NIB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/program_sequencer_step_pulse_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : step_pulse_gen
// Purpose  : Phase timer for SETUP/HI/LO; issues phase-done strobes and the
//            registered step clock.
// Revision : 1.0
// ---------------------------------------------------------------------------
module step_pulse_gen
  import bitblaster_pkg::*;
#(
  parameter int HALF_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  seq_state_t i_state,
  input  seq_state_t i_state_next,
  output logic       o_setup_done,
  output logic       o_hi_done,
  output logic       o_lo_done,
  output logic       o_step_clk
);

  localparam int            TW       = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(HALF_CYC - 1);

  logic [TW-1:0] tmr_q, tmr_d;
  logic          step_clk_q, step_clk_d;
  logic          in_phase;
  logic          phase_last;

  always_comb begin
    in_phase     = (i_state == ST_SETUP) || (i_state == ST_HI) || (i_state == ST_LO);
    phase_last   = in_phase && (tmr_q == TMR_LAST);
    tmr_d        = (in_phase && !phase_last) ? tmr_q + 1'b1 : '0;
    // Registered from the next state so the button line is glitch-free.
    step_clk_d   = (i_state_next == ST_HI);
    o_setup_done = phase_last && (i_state == ST_SETUP);
    o_hi_done    = phase_last && (i_state == ST_HI);
    o_lo_done    = phase_last && (i_state == ST_LO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q      <= '0;
      step_clk_q <= 1'b0;
    end else begin
      tmr_q      <= tmr_d;
      step_clk_q <= step_clk_d;
    end
  end

  assign o_step_clk = step_clk_q;

endmodule
`default_nettype wire

// File: rtl/program_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : program_sequencer
// Purpose  : Replays a stored program into the processor switch/step-button
//            inputs, using the done flag to find instruction boundaries.
// Revision : 1.0
// ---------------------------------------------------------------------------
module program_sequencer
  import bitblaster_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AW        = $clog2(DEPTH),
  parameter int HALF_CYC  = 16,
  parameter int MAX_STEPS = 4
) (
  input  logic          CLK_50MHz,
  input  logic          CLR,
  input  logic          PRG_WE,
  input  logic [AW-1:0] PRG_WADDR,
  input  logic [9:0]    PRG_WDATA,
  input  logic [AW:0]   PRG_LEN,
  input  logic          START,
  input  logic          DONE_I,
  output logic [9:0]    DATA_O,
  output logic          STEP_CLK_O,
  output logic          BUSY,
  output logic          FINISHED,
  output logic          ERR,
  output logic [AW:0]   PC_O
);

  localparam int            CW      = $clog2(MAX_STEPS + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_TWO = CW'(2);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_STEPS);
  localparam logic [AW:0]   LEN_MAX = (AW + 1)'(DEPTH);

  seq_state_t    state_q, state_d;
  logic [AW:0]   pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_ld_q, is_ld_d;
  logic          final_q, final_d;
  logic [9:0]    mem_q [DEPTH];

  logic          busy;
  logic          pc_in_range;
  logic [9:0]    rd_word;
  logic          pc_step;
  logic [AW:0]   pc_next;
  logic          setup_done, hi_done, lo_done;

  step_pulse_gen #(
    .HALF_CYC (HALF_CYC)
  ) u_pulse (
    .clk          (CLK_50MHz),
    .rst          (CLR),
    .i_state      (state_q),
    .i_state_next (state_d),
    .o_setup_done (setup_done),
    .o_hi_done    (hi_done),
    .o_lo_done    (lo_done),
    .o_step_clk   (STEP_CLK_O)
  );

  always_comb begin
    busy        = (state_q == ST_SETUP) || (state_q == ST_HI) || (state_q == ST_LO);
    pc_in_range = (pc_q < len_q);
    // Past the end of the program the switches read zero; memory is never indexed there.
    rd_word     = pc_in_range ? mem_q[pc_q[AW-1:0]] : '0;
    pc_step     = (cnt_q == CNT_ONE) || ((cnt_q == CNT_TWO) && is_ld_q);
    pc_next     = (pc_step && pc_in_range) ? pc_q + 1'b1 : pc_q;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    is_ld_d = is_ld_q;
    final_d = final_q;
    case (state_q)
      ST_IDLE, ST_FINISHED, ST_ERROR: begin
        if (START) begin
          len_d   = (PRG_LEN > LEN_MAX) ? LEN_MAX : PRG_LEN;
          pc_d    = '0;
          cnt_d   = CNT_ONE;
          is_ld_d = 1'b0;
          final_d = 1'b0;
          state_d = (PRG_LEN == '0) ? ST_FINISHED : ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (setup_done) begin
          if (cnt_q == CNT_ONE) begin
            is_ld_d = is_ld_word(rd_word);
            final_d = 1'b0;
          end else begin
            final_d = DONE_I;
          end
          state_d = ST_HI;
        end
      end
      ST_HI: begin
        if (hi_done) state_d = ST_LO;
      end
      ST_LO: begin
        if (lo_done) begin
          pc_d = pc_next;
          if (final_q) begin
            cnt_d   = CNT_ONE;
            state_d = (pc_next == len_q) ? ST_FINISHED : ST_SETUP;
          end else if (cnt_q == CNT_MAX) begin
            state_d = ST_ERROR;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_SETUP;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50MHz) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      is_ld_q <= 1'b0;
      final_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      is_ld_q <= is_ld_d;
      final_q <= final_d;
    end
  end

  // Program storage deliberately survives CLR.
  always_ff @(posedge CLK_50MHz) begin
    if (PRG_WE && !busy) mem_q[PRG_WADDR] <= PRG_WDATA;
  end

  assign DATA_O   = busy ? rd_word : '0;
  assign BUSY     = busy;
  assign FINISHED = (state_q == ST_FINISHED);
  assign ERR      = (state_q == ST_ERROR);
  assign PC_O     = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_program_sequencer
// Purpose  : Directed bench with a simple processor model and a per-pulse
//            DATA_O scoreboard.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_program_sequencer;

  localparam int DEPTH     = 16;
  localparam int AW        = 4;
  localparam int HALF_CYC  = 3;
  localparam int MAX_STEPS = 4;
  localparam int STEP_CYC  = 3 * HALF_CYC;

  logic          clk       = 1'b0;
  logic          clr       = 1'b1;
  logic          prg_we    = 1'b0;
  logic [AW-1:0] prg_waddr = '0;
  logic [9:0]    prg_wdata = '0;
  logic [AW:0]   prg_len   = '0;
  logic          start     = 1'b0;
  logic          done_i;
  logic [9:0]    data_o;
  logic          step_clk, busy, finished, err;
  logic [AW:0]   pc_o;

  int         checks    = 0;
  int         fails     = 0;
  int         pulse_cnt = 0;
  int         pcount    = 0;
  logic [9:0] cur_word  = '0;
  logic       step_prev = 1'b0;
  logic [9:0] sb [$];

  program_sequencer #(
    .DEPTH     (DEPTH),
    .AW        (AW),
    .HALF_CYC  (HALF_CYC),
    .MAX_STEPS (MAX_STEPS)
  ) dut (
    .CLK_50MHz  (clk),
    .CLR        (clr),
    .PRG_WE     (prg_we),
    .PRG_WADDR  (prg_waddr),
    .PRG_WDATA  (prg_wdata),
    .PRG_LEN    (prg_len),
    .START      (start),
    .DONE_I     (done_i),
    .DATA_O     (data_o),
    .STEP_CLK_O (step_clk),
    .BUSY       (busy),
    .FINISHED   (finished),
    .ERR        (err),
    .PC_O       (pc_o)
  );

  always #5 clk = ~clk;

  // Steps each known instruction needs on the processor; 0 means it never completes.
  function automatic int steps_for(input logic [9:0] w);
    case (w)
      10'b0000000000: return 2;
      10'b1000000011: return 3;
      10'b0000010010: return 0;
      default:        return 2;
    endcase
  endfunction

  assign done_i = (pcount != 0) && ((pcount + 1) == steps_for(cur_word));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (step_clk && !step_prev) begin
      pulse_cnt++;
      check("pulse_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check("pulse_data", 32'(data_o), 32'(sb.pop_front()));
      if (pcount == 0) begin
        cur_word = data_o;
        pcount   = 1;
      end else begin
        pcount++;
      end
      if (pcount == steps_for(cur_word)) pcount = 0;
    end
    step_prev = step_clk;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_word(input int a, input logic [9:0] d);
    prg_we    = 1'b1;
    prg_waddr = AW'(a);
    prg_wdata = d;
    tick();
    prg_we    = 1'b0;
  endtask

  task automatic do_start(input int len);
    pcount    = 0;
    pulse_cnt = 0;
    prg_len   = (AW + 1)'(len);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic run_to_idle(input string tag, output int cyc);
    cyc = 0;
    while (busy && cyc < 2000) begin
      tick();
      cyc++;
    end
    check({tag, "_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_pulses(input string tag, input int n);
    int c;
    c = 0;
    while (pulse_cnt < n && c < 500) begin
      tick();
      c++;
    end
    check({tag, "_pulse_wait"}, 32'(pulse_cnt >= n), 32'd1);
  endtask

  initial begin
    int cyc;

    // Reset, preload program, reset again: memory must survive.
    clr = 1'b1; tick(2); clr = 1'b0;
    write_word(0, 10'h000);
    write_word(1, 10'h005);
    write_word(2, 10'b1000000011);
    clr = 1'b1; tick(2);
    check("rst_data",     32'(data_o),   32'd0);
    check("rst_step",     32'(step_clk), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_finished", 32'(finished), 32'd0);
    check("rst_err",      32'(err),      32'd0);
    check("rst_pc",       32'(pc_o),     32'd0);
    clr = 1'b0; tick();

    // ld 0 / operand 5 / addi: ld takes 2 pulses, addi 3.
    sb.push_back(10'h000); sb.push_back(10'h005); sb.push_back(10'h203);
    sb.push_back(10'h000); sb.push_back(10'h000);
    do_start(3);
    check("p1_busy", 32'(busy), 32'd1);
    run_to_idle("p1", cyc);
    check("p1_cycles",   32'(cyc),       32'(5 * STEP_CYC));
    check("p1_finished", 32'(finished),  32'd1);
    check("p1_err",      32'(err),       32'd0);
    check("p1_pc",       32'(pc_o),      32'd3);
    check("p1_pulses",   32'(pulse_cnt), 32'd5);
    check("p1_sb_empty", 32'(sb.size()), 32'd0);

    // An add that never completes stops after MAX_STEPS pulses.
    write_word(0, 10'b0000010010);
    sb.push_back(10'h012); sb.push_back(10'h000); sb.push_back(10'h000); sb.push_back(10'h000);
    do_start(1);
    run_to_idle("err", cyc);
    check("err_cycles",   32'(cyc),       32'(MAX_STEPS * STEP_CYC));
    check("err_flag",     32'(err),       32'd1);
    check("err_finished", 32'(finished),  32'd0);
    check("err_step",     32'(step_clk),  32'd0);
    check("err_pulses",   32'(pulse_cnt), 32'd4);
    tick(4 * STEP_CYC);
    check("err_no_more_pulses", 32'(pulse_cnt), 32'd4);
    check("err_held",           32'(err),       32'd1);

    // Empty program finishes on the next cycle.
    do_start(0);
    check("len0_finished", 32'(finished), 32'd1);
    check("len0_busy",     32'(busy),     32'd0);
    check("len0_err",      32'(err),      32'd0);
    tick(2 * STEP_CYC);
    check("len0_pulses",   32'(pulse_cnt), 32'd0);

    // START/PRG_WE during HI of pulse 2 are ignored; CLR during HI of pulse 3 aborts.
    write_word(0, 10'h000);
    sb.push_back(10'h000); sb.push_back(10'h005); sb.push_back(10'h203);
    do_start(3);
    wait_pulses("inj", 2);
    check("inj_step_hi", 32'(step_clk), 32'd1);
    prg_we = 1'b1; prg_waddr = '0; prg_wdata = 10'h3FF;
    start  = 1'b1; prg_len = '0;
    tick();
    prg_we = 1'b0; start = 1'b0;
    check("inj_busy", 32'(busy), 32'd1);
    check("inj_pc",   32'(pc_o), 32'd1);
    wait_pulses("clr", 3);
    check("clr_step_hi", 32'(step_clk), 32'd1);
    clr = 1'b1; tick();
    check("clr_step",     32'(step_clk), 32'd0);
    check("clr_busy",     32'(busy),     32'd0);
    check("clr_pc",       32'(pc_o),     32'd0);
    check("clr_finished", 32'(finished), 32'd0);
    check("clr_sb_empty", 32'(sb.size()), 32'd0);
    clr = 1'b0; tick();

    // Rerun: first word must still be the ld, not the ignored write.
    sb.push_back(10'h000); sb.push_back(10'h005); sb.push_back(10'h203);
    sb.push_back(10'h000); sb.push_back(10'h000);
    do_start(3);
    run_to_idle("rerun", cyc);
    check("rerun_finished", 32'(finished),  32'd1);
    check("rerun_pulses",   32'(pulse_cnt), 32'd5);
    check("rerun_sb_empty", 32'(sb.size()), 32'd0);

    // Trailing ld with no operand: T1 sees zero, not mem[1].
    sb.push_back(10'h000); sb.push_back(10'h000);
    do_start(1);
    run_to_idle("tld", cyc);
    check("tld_cycles",   32'(cyc),       32'(2 * STEP_CYC));
    check("tld_finished", 32'(finished),  32'd1);
    check("tld_pc",       32'(pc_o),      32'd1);
    check("tld_pulses",   32'(pulse_cnt), 32'd2);
    check("tld_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
